// File: rtl/s6_icap_pkg.sv
// Shared constants for the Spartan-6 ICAP multiboot sequencer: ICAP command
// words, Wishbone register map, FSM encoding and a byte bit-reversal helper.
// Optional build macro: S6_ICAP_BITSWAP_EN (selects bit-reversed ICAP bytes).
package s6_icap_pkg;

    // Word index width; wide enough for 13 + 8 words without wrapping.
    localparam int IDX_W        = 5;
    localparam int SEQ_LEN_BASE = 13;

    // ICAP configuration words
    localparam logic [15:0] W_DUMMY    = 16'hFFFF;
    localparam logic [15:0] W_SYNC0    = 16'hAA99;
    localparam logic [15:0] W_SYNC1    = 16'h5566;
    localparam logic [15:0] W_HDR_GEN1 = 16'h3261;
    localparam logic [15:0] W_HDR_GEN2 = 16'h3281;
    localparam logic [15:0] W_HDR_GEN3 = 16'h32A1;
    localparam logic [15:0] W_HDR_GEN4 = 16'h32C1;
    localparam logic [15:0] W_HDR_CMD  = 16'h30A1;
    localparam logic [15:0] W_IPROG    = 16'h000E;
    localparam logic [15:0] W_NOOP     = 16'h2000;

    // Wishbone register addresses
    localparam logic [1:0] ADR_MB     = 2'd0;
    localparam logic [1:0] ADR_GOLD   = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reverse bit order inside each byte (bit0<->bit7) of a 16-bit word.
    function automatic logic [15:0] byte_bitswap(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        for (int b = 0; b < 8; b++) begin
            r[b]     = w[7 - b];
            r[8 + b] = w[15 - b];
        end
        return r;
    endfunction

endpackage

// File: rtl/s6_iprog_seq_rom.sv
// Combinational IPROG command table: maps a word index plus the snapshotted
// multiboot/golden addresses to the 16-bit ICAP word for that position.
module s6_iprog_seq_rom
    import s6_icap_pkg::*;
#(
    parameter logic [7:0] SPI_RD_OP = 8'h03
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [23:0]      mb_addr,
    input  logic [23:0]      gold_addr,
    output logic [15:0]      word
);

    // Table lookup; every index past IPROG is a trailing NOOP.
    always_comb begin
        word = W_NOOP;
        case (idx)
            5'd0:    word = W_DUMMY;
            5'd1:    word = W_SYNC0;
            5'd2:    word = W_SYNC1;
            5'd3:    word = W_HDR_GEN1;
            5'd4:    word = mb_addr[15:0];
            5'd5:    word = W_HDR_GEN2;
            5'd6:    word = {SPI_RD_OP, mb_addr[23:16]};
            5'd7:    word = W_HDR_GEN3;
            5'd8:    word = gold_addr[15:0];
            5'd9:    word = W_HDR_GEN4;
            5'd10:   word = {SPI_RD_OP, gold_addr[23:16]};
            5'd11:   word = W_HDR_CMD;
            5'd12:   word = W_IPROG;
            default: word = W_NOOP;
        endcase
    end

endmodule

// File: rtl/s6_multiboot_ctrl.sv
// Wishbone-controlled Spartan-6 multiboot sequencer. A GO write snapshots the
// multiboot/golden addresses and streams the IPROG sequence into the ICAP
// write port, stalling on ICAP BUSY.
// Optional build macro: S6_ICAP_BITSWAP_EN bit-reverses each ICAP byte.
module s6_multiboot_ctrl
    import s6_icap_pkg::*;
#(
    parameter int         NUM_NOOP  = 2,
    parameter logic [7:0] SPI_RD_OP = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic        icap_busy,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_din
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN_BASE + NUM_NOOP - 1);

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              ack_r, go_r, done_r;
    logic [31:0]       dat_r, rd_s;
    logic [23:0]       mb_r, gold_r, mb_shd_r, gold_shd_r;
    logic              ce_n_r, write_n_r;
    logic [15:0]       din_r, word_s, word_out_s;
    logic              acc_s, wr_s, go_wr_s, busy_s;
    logic              unused_s;

    assign unused_s = ^dat_i[31:24];

    // Word for the index about to be presented
    s6_iprog_seq_rom #(.SPI_RD_OP(SPI_RD_OP)) u_rom (
        .idx       (idx_s),
        .mb_addr   (mb_shd_r),
        .gold_addr (gold_shd_r),
        .word      (word_s)
    );

    // Bus decode: a new access is one not yet acknowledged
    always_comb begin
        busy_s  = (state_r != ST_IDLE);
        acc_s   = cyc_i & stb_i & ~ack_r;
        wr_s    = acc_s & we_i;
        go_wr_s = wr_s & (adr_i == ADR_CTRL) & dat_i[0] & ~busy_s & ~go_r;
    end

    // Read data multiplexer
    always_comb begin
        rd_s = 32'h0000_0000;
        case (adr_i)
            ADR_MB:     rd_s = {8'h00, mb_r};
            ADR_GOLD:   rd_s = {8'h00, gold_r};
            ADR_CTRL:   rd_s = 32'h0000_0000;
            ADR_STATUS: rd_s = {24'h00_0000, idx_r[3:0], 2'b00, done_r, busy_s};
            default:    rd_s = 32'h0000_0000;
        endcase
    end

    // Single-cycle Wishbone acknowledge and registered read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= acc_s;
            dat_r <= (acc_s & ~we_i) ? rd_s : 32'h0000_0000;
        end
    end

    // Live address registers, writable at any time
    always_ff @(posedge clk) begin
        if (!reset) begin
            mb_r   <= 24'h00_0000;
            gold_r <= 24'h00_0000;
        end else begin
            if (wr_s && adr_i == ADR_MB)   mb_r   <= dat_i[23:0];
            if (wr_s && adr_i == ADR_GOLD) gold_r <= dat_i[23:0];
        end
    end

    // GO request, address snapshot and sticky done flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            go_r       <= 1'b0;
            done_r     <= 1'b0;
            mb_shd_r   <= 24'h00_0000;
            gold_shd_r <= 24'h00_0000;
        end else begin
            go_r <= go_wr_s;
            if (go_wr_s) begin
                done_r     <= 1'b0;
                mb_shd_r   <= mb_r;
                gold_shd_r <= gold_r;
            end else if (state_r == ST_RUN && state_s == ST_DONE) begin
                done_r <= 1'b1;
            end
        end
    end

    // Next state and word index; BUSY freezes the index on the current word
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                idx_s = 5'd0;
                if (go_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (icap_busy) begin
                    idx_s = idx_r;
                end else if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                    idx_s   = 5'd0;
                end else begin
                    idx_s = idx_r + 5'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                idx_s   = 5'd0;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 5'd0;
            end
        endcase
    end

    // Optional per-byte bit reversal ahead of the output register
    always_comb begin
`ifdef S6_ICAP_BITSWAP_EN
        word_out_s = byte_bitswap(word_s);
`else
        word_out_s = word_s;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Registered ICAP port, aligned with the state/index just loaded
    always_ff @(posedge clk) begin
        if (!reset) begin
            ce_n_r    <= 1'b1;
            write_n_r <= 1'b1;
            din_r     <= 16'hFFFF;
        end else if (state_s == ST_RUN) begin
            ce_n_r    <= 1'b0;
            write_n_r <= 1'b0;
            din_r     <= word_out_s;
        end else begin
            ce_n_r    <= 1'b1;
            write_n_r <= 1'b1;
            din_r     <= 16'hFFFF;
        end
    end

    assign ack_o        = ack_r;
    assign dat_o        = dat_r;
    assign icap_ce_n    = ce_n_r;
    assign icap_write_n = write_n_r;
    assign icap_din     = din_r;

endmodule

// File: tb/tb_s6_multiboot_ctrl.sv
// Directed bench for s6_multiboot_ctrl (default NUM_NOOP=2, SPI_RD_OP=03).
// Honours S6_ICAP_BITSWAP_EN for the expected ICAP words.
module tb_s6_multiboot_ctrl;

    localparam int SEQ_WORDS = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [1:0]  adr_i = 2'd0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        icap_busy = 1'b0;
    logic        icap_ce_n, icap_write_n;
    logic [15:0] icap_din;

    int n_checks = 0;
    int n_err    = 0;

    s6_multiboot_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cyc_i        (cyc_i),
        .stb_i        (stb_i),
        .we_i         (we_i),
        .adr_i        (adr_i),
        .dat_i        (dat_i),
        .dat_o        (dat_o),
        .ack_o        (ack_o),
        .icap_busy    (icap_busy),
        .icap_ce_n    (icap_ce_n),
        .icap_write_n (icap_write_n),
        .icap_din     (icap_din)
    );

    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bswap(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        for (int b = 0; b < 8; b++) begin
            r[b]     = w[7 - b];
            r[8 + b] = w[15 - b];
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_word(input int i, input logic [23:0] mb, input logic [23:0] gold);
        logic [15:0] w;
        case (i)
            0:       w = 16'hFFFF;
            1:       w = 16'hAA99;
            2:       w = 16'h5566;
            3:       w = 16'h3261;
            4:       w = mb[15:0];
            5:       w = 16'h3281;
            6:       w = {8'h03, mb[23:16]};
            7:       w = 16'h32A1;
            8:       w = gold[15:0];
            9:       w = 16'h32C1;
            10:      w = {8'h03, gold[23:16]};
            11:      w = 16'h30A1;
            12:      w = 16'h000E;
            default: w = 16'h2000;
        endcase
`ifdef S6_ICAP_BITSWAP_EN
        w = bswap(w);
`endif
        return w;
    endfunction

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
        @(posedge clk);
        @(negedge clk);
        check("wr_ack", {31'h0, ack_o}, 32'h1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ack"}, {31'h0, ack_o}, 32'h1);
        check(tag, dat_o, exp);
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    // Samples every cycle after a GO ack; stalls on sample stall_at for stall_len
    // cycles of BUSY, and optionally pulls reset right after sample abort_at.
    task automatic run_seq(input string name, input logic [23:0] mb, input logic [23:0] gold,
                           input int stall_at, input int stall_len, input int abort_at,
                           output int words);
        int  k;
        int  ei;
        bit  fin;
        k = 0;
        fin = 1'b0;
        for (int c = 0; c < 80 && !fin; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (icap_ce_n == 1'b0) begin
                if (k <= stall_at)                  ei = k;
                else if (k <= stall_at + stall_len) ei = stall_at;
                else                                ei = k - stall_len;
                check({name, "_word"}, {15'h0, icap_write_n, icap_din}, {16'h0, exp_word(ei, mb, gold)});
                icap_busy = (k >= stall_at) && (k < stall_at + stall_len);
                if (k == abort_at) begin
                    reset = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    check({name, "_abort_ce"}, {31'h0, icap_ce_n}, 32'h1);
                    reset = 1'b1;
                    fin = 1'b1;
                end
                k++;
            end else if (k > 0) begin
                fin = 1'b1;
            end
        end
        icap_busy = 1'b0;
        words = k;
    endtask

    initial begin
        int n;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ce_n", {31'h0, icap_ce_n}, 32'h1);
        check("rst_write_n", {31'h0, icap_write_n}, 32'h1);
        check("rst_ack", {31'h0, ack_o}, 32'h0);
        check("rst_din", {16'h0, icap_din}, 32'h0000_FFFF);
        check("rst_dat", dat_o, 32'h0);
        reset = 1'b1;
        wb_read("rst_status", 2'd3, 32'h0);
        wb_read("rst_mb", 2'd0, 32'h0);

        // Register access; upper byte of MB must read zero
        wb_write(2'd0, 32'hAB06_0000);
        wb_write(2'd1, 32'h0000_0000);
        wb_read("rd_mb", 2'd0, 32'h0006_0000);
        wb_read("rd_gold", 2'd1, 32'h0);
        wb_read("rd_ctrl", 2'd2, 32'h0);

        // Nominal sequence
        wb_write(2'd2, 32'h1);
        run_seq("nom", 24'h060000, 24'h000000, 99, 0, -1, n);
        check("nom_len", n, SEQ_WORDS);
        wb_read("nom_status", 2'd3, 32'h2);

        // BUSY stall at index 5 for 3 cycles
        wb_write(2'd2, 32'h1);
        run_seq("stall", 24'h060000, 24'h000000, 5, 3, -1, n);
        check("stall_len", n, SEQ_WORDS + 3);
        wb_read("stall_status", 2'd3, 32'h2);

        // GO and MB write during RUN must not disturb the running sequence
        wb_write(2'd2, 32'h1);
        fork
            run_seq("live", 24'h060000, 24'h000000, 99, 0, -1, n);
            begin
                repeat (4) @(negedge clk);
                wb_write(2'd0, 32'h0012_3456);
                wb_write(2'd2, 32'h1);
            end
        join
        check("live_len", n, SEQ_WORDS);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("live_no_restart", {31'h0, icap_ce_n}, 32'h1);
        end
        wb_read("live_mb", 2'd0, 32'h0012_3456);

        // Reset while index 7 is on the port
        wb_write(2'd2, 32'h1);
        run_seq("abort", 24'h123456, 24'h000000, 99, 0, 7, n);
        check("abort_len", n, 8);
        wb_read("abort_status", 2'd3, 32'h0);
        wb_read("abort_mb", 2'd0, 32'h0);

        // Fresh GO after the abort restarts from the dummy word
        wb_write(2'd2, 32'h1);
        run_seq("restart", 24'h000000, 24'h000000, 99, 0, -1, n);
        check("restart_len", n, SEQ_WORDS);
        wb_read("restart_status", 2'd3, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
